// File: rtl/i2c_slave_if.sv
// i2c_slave_if: I2C target pins plus write/read byte-stream handshakes
// slave modport : scl, sda_i, write_ready, read_data, read_valid in; sda_o, write_data, write_valid, read_ready out
// master modport: the mirror image, for the bus/host side
interface i2c_slave_if;
  logic       scl;
  logic       sda_i;
  logic       sda_o;
  logic [7:0] write_data;
  logic       write_valid;
  logic       write_ready;
  logic [7:0] read_data;
  logic       read_valid;
  logic       read_ready;
  modport slave (
    input  scl, sda_i, write_ready, read_data, read_valid,
    output sda_o, write_data, write_valid, read_ready
  );
  modport master (
    output scl, sda_i, write_ready, read_data, read_valid,
    input  sda_o, write_data, write_valid, read_ready
  );
endinterface

// File: rtl/i2c_slave.sv
// i2c_slave: oversampled I2C target bridging bus writes/reads to byte streams
// clk   in  system clock, rising edge
// rst_n in  asynchronous active-low reset
// bus   i2c_slave_if.slave: scl/sda_i in, sda_o open-drain out (0 = pull low),
//       write_data/write_valid out with write_ready in, read_data/read_valid in with read_ready out
module i2c_slave #(
  parameter logic [6:0] ADDRESS = 7'h2F
) (
  input  logic        clk,
  input  logic        rst_n,
  i2c_slave_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE} state_t;
  state_t     state_q;
  logic [2:0] scl_q, sda_q;
  logic [3:0] cnt_q;
  logic [6:0] sh_q;
  logic [7:0] write_data_q;
  logic       sda_o_q, write_valid_q, read_ready_q, rw_q, ack_q;
  logic       sda_s, scl_rise, scl_fall, start, stop;
  logic [7:0] sh_in, ld_byte;
  // [1] is the synchronised level, [2] the history bit used for edge detection
  assign sda_s    = sda_q[1];
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start    = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop     = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
  assign sh_in    = {sh_q, sda_s};
  // an empty read stream is answered with all-ones (bus released)
  assign ld_byte  = bus.read_valid ? bus.read_data : 8'hFF;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      scl_q         <= '1;
      sda_q         <= '1;
      state_q       <= IDLE;
      cnt_q         <= '0;
      sh_q          <= '0;
      write_data_q  <= '0;
      sda_o_q       <= 1'b1;
      write_valid_q <= 1'b0;
      read_ready_q  <= 1'b0;
      rw_q          <= 1'b0;
      ack_q         <= 1'b0;
    end else begin
      scl_q         <= {scl_q[1:0], bus.scl};
      sda_q         <= {sda_q[1:0], bus.sda_i};
      write_valid_q <= 1'b0;
      read_ready_q  <= 1'b0;
      if (start) begin
        state_q <= ADDR;
        cnt_q   <= '0;
        sda_o_q <= 1'b1;
      end else if (stop) begin
        state_q <= IDLE;
        sda_o_q <= 1'b1;
      end else
        case (state_q)
          ADDR:
            if (scl_rise && cnt_q < 4'd8) begin
              sh_q  <= sh_in[6:0];
              cnt_q <= cnt_q + 4'd1;
              if (cnt_q == 4'd7) begin
                rw_q <= sda_s;
                if (sh_in[7:1] != ADDRESS) state_q <= IGNORE;
              end
            end else if (scl_fall && cnt_q == 4'd8) begin
              sda_o_q <= 1'b0;
              state_q <= ADDR_ACK;
            end
          ADDR_ACK:
            if (scl_fall) begin
              cnt_q <= '0;
              if (rw_q) begin
                state_q      <= READ;
                sh_q         <= ld_byte[6:0];
                sda_o_q      <= ld_byte[7];
                read_ready_q <= bus.read_valid;
              end else begin
                state_q <= WRITE;
                sda_o_q <= 1'b1;
              end
            end
          WRITE:
            if (scl_rise && cnt_q < 4'd8) begin
              sh_q  <= sh_in[6:0];
              cnt_q <= cnt_q + 4'd1;
              if (cnt_q == 4'd7) begin
                write_data_q  <= sh_in;
                write_valid_q <= 1'b1;
              end
            end else if (write_valid_q)
              ack_q <= bus.write_ready;
            else if (scl_fall && cnt_q == 4'd8) begin
              sda_o_q <= ~ack_q;
              state_q <= WRITE_ACK;
            end
          WRITE_ACK:
            if (scl_fall) begin
              sda_o_q <= 1'b1;
              cnt_q   <= '0;
              state_q <= ack_q ? WRITE : IGNORE;
            end
          READ:
            if (scl_rise && cnt_q < 4'd8)
              cnt_q <= cnt_q + 4'd1;
            else if (scl_fall && cnt_q == 4'd8) begin
              sda_o_q <= 1'b1;
              state_q <= READ_ACK;
            end else if (scl_fall) begin
              sda_o_q <= sh_q[6];
              sh_q    <= {sh_q[5:0], 1'b1};
            end
          READ_ACK:
            if (scl_rise)
              ack_q <= ~sda_s;
            else if (scl_fall) begin
              cnt_q <= '0;
              if (ack_q) begin
                state_q      <= READ;
                sh_q         <= ld_byte[6:0];
                sda_o_q      <= ld_byte[7];
                read_ready_q <= bus.read_valid;
              end else begin
                state_q <= IGNORE;
                sda_o_q <= 1'b1;
              end
            end
          default: ;
        endcase
    end
  assign bus.sda_o       = sda_o_q;
  assign bus.write_data  = write_data_q;
  assign bus.write_valid = write_valid_q;
  assign bus.read_ready  = read_ready_q;
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: table-driven I2C master model checking the i2c_slave target
module tb_i2c_slave;
  localparam int H = 8;
  typedef struct {
    logic [6:0] addr;
    logic       rw;
    int         nb;
    logic [7:0] b0, b1;
    logic       wr_rdy, rd_vld;
    logic       e_aack;
    logic [1:0] e_dack;
    logic [7:0] e_rd;
    int         e_wv, e_rr;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, sda_m = 1'b1;
  int tests = 0, fails = 0, vid = 0;
  int wv_tot = 0, rr_tot = 0, both_tot = 0;
  logic [7:0] wd_log [64];
  vec_t v [6];
  always #5 clk = ~clk;
  i2c_slave_if bus();
  i2c_slave #(.ADDRESS(7'h2F)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.sda_i = sda_m & bus.sda_o;
  always @(negedge clk) begin
    if (bus.write_valid) begin
      wd_log[wv_tot & 63] = bus.write_data;
      wv_tot++;
    end
    if (bus.read_ready) rr_tot++;
    if (bus.write_valid && bus.read_ready) both_tot++;
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL v%0d %s: got %0h expected %0h", vid, nm, act, exp);
    end
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic clk_bit(input logic b, output logic s);
    sda_m = b;
    wait_clk(H);
    bus.scl = 1'b1;
    wait_clk(H / 2);
    s = bus.sda_o;
    wait_clk(H / 2);
    bus.scl = 1'b0;
    wait_clk(H);
  endtask
  task automatic do_start;
    sda_m = 1'b1;
    wait_clk(H);
    bus.scl = 1'b1;
    wait_clk(H);
    sda_m = 1'b0;
    wait_clk(H);
    bus.scl = 1'b0;
    wait_clk(H);
  endtask
  task automatic do_stop;
    sda_m = 1'b0;
    wait_clk(H);
    bus.scl = 1'b1;
    wait_clk(H);
    sda_m = 1'b1;
    wait_clk(H);
  endtask
  task automatic send_addr(input logic [7:0] ab, output logic rel);
    logic s;
    rel = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(ab[i], s);
      rel &= s;
    end
  endtask
  task automatic run(input vec_t t);
    logic s, rel;
    logic [1:0] dack;
    logic [7:0] rb, by;
    int wv0, rr0;
    bus.write_ready = t.wr_rdy;
    bus.read_data   = t.b0;
    bus.read_valid  = t.rd_vld;
    wv0  = wv_tot;
    rr0  = rr_tot;
    dack = 2'b00;
    do_start;
    send_addr({t.addr, t.rw}, rel);
    clk_bit(1'b1, s);
    check("addr_ack", s, t.e_aack);
    if (!t.rw) begin
      for (int k = 0; k < t.nb; k++) begin
        by = (k == 0) ? t.b0 : t.b1;
        for (int i = 7; i >= 0; i--) begin
          clk_bit(by[i], s);
          rel &= s;
        end
        clk_bit(1'b1, s);
        dack[k] = s;
      end
      check("data_ack", dack, t.e_dack);
    end else begin
      for (int k = 0; k < t.nb; k++) begin
        for (int i = 7; i >= 0; i--) begin
          clk_bit(1'b1, s);
          rb[i] = s;
        end
        check("read_byte", rb, t.e_rd);
        clk_bit(k == t.nb - 1, s);
        check("read_ack_released", s, 1);
      end
    end
    check("released_while_master_drives", rel, 1);
    do_stop;
    wait_clk(H);
    check("sda_after_stop", bus.sda_o, 1);
    check("write_valid_count", wv_tot - wv0, t.e_wv);
    check("read_ready_count", rr_tot - rr0, t.e_rr);
    if (t.e_wv >= 1) check("write_data0", wd_log[wv0 & 63], t.b0);
    if (t.e_wv >= 2) check("write_data1", wd_log[(wv0 + 1) & 63], t.b1);
    check("wv_rr_overlap", both_tot, 0);
  endtask
  initial begin
    logic s, rel;
    int w0;
    v[0] = '{7'h2F, 1'b0, 2, 8'hAA, 8'h55, 1'b1, 1'b1, 1'b0, 2'b00, 8'h00, 2, 0};
    v[1] = '{7'h2F, 1'b1, 2, 8'h42, 8'h00, 1'b1, 1'b1, 1'b0, 2'b00, 8'h42, 0, 2};
    v[2] = '{7'h2E, 1'b0, 1, 8'hAA, 8'h00, 1'b1, 1'b1, 1'b1, 2'b01, 8'h00, 0, 0};
    v[3] = '{7'h2F, 1'b0, 2, 8'h12, 8'h34, 1'b0, 1'b1, 1'b0, 2'b11, 8'h00, 1, 0};
    v[4] = '{7'h2F, 1'b1, 1, 8'h42, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 8'hFF, 0, 0};
    v[5] = '{7'h2F, 1'b0, 1, 8'h3C, 8'h00, 1'b1, 1'b1, 1'b0, 2'b00, 8'h00, 1, 0};
    bus.scl = 1'b1;
    bus.write_ready = 1'b1;
    bus.read_data = 8'h00;
    bus.read_valid = 1'b0;
    wait_clk(3);
    check("reset_sda_o", bus.sda_o, 1);
    check("reset_write_valid", bus.write_valid, 0);
    check("reset_read_ready", bus.read_ready, 0);
    check("reset_write_data", bus.write_data, 0);
    rst_n = 1'b1;
    wait_clk(H);
    for (int i = 0; i < 6; i++) begin
      vid = i;
      run(v[i]);
    end
    vid = 6;
    bus.write_ready = 1'b1;
    do_start;
    send_addr(8'h5E, rel);
    sda_m = 1'b1;
    wait_clk(H);
    check("ack_before_reset", bus.sda_o, 0);
    rst_n = 1'b0;
    #1;
    check("sda_o_at_reset", bus.sda_o, 1);
    check("write_valid_at_reset", bus.write_valid, 0);
    wait_clk(2);
    rst_n = 1'b1;
    bus.scl = 1'b1;
    sda_m = 1'b1;
    wait_clk(H);
    run(v[5]);
    vid = 7;
    w0 = wv_tot;
    do_start;
    send_addr(8'h5E, rel);
    clk_bit(1'b1, s);
    check("abort_addr_ack", s, 0);
    for (int i = 0; i < 4; i++) clk_bit(1'b1, s);
    check("abort_no_write_valid", wv_tot - w0, 0);
    run(v[5]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
